// File: rtl/line_writeback.sv
// line_writeback: drains victim-cache lines to memory as AXI INCR bursts.
// Tracks the in-flight line label so the miss path can stall on a hazard.

module line_writeback #(
    parameter  int LINE_WIDTH       = 256,
    parameter  int DATA_WIDTH       = 32,
    localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
    localparam int LABEL_WIDTH      = 32 - LINE_BYTE_OFFSET,
    localparam int BEATS            = LINE_WIDTH / DATA_WIDTH,
    localparam int CNT_WIDTH        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] rline,
    input  logic                              empty,
    output logic                              pop,
    output logic [31:0]                       awaddr,
    output logic [7:0]                        awlen,
    output logic [2:0]                        awsize,
    output logic [1:0]                        awburst,
    output logic                              awvalid,
    input  logic                              awready,
    output logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH/8-1:0]           wstrb,
    output logic                              wlast,
    output logic                              wvalid,
    input  logic                              wready,
    input  logic [1:0]                        bresp,
    input  logic                              bvalid,
    output logic                              bready,
    output logic                              inflight_valid,
    output logic [LABEL_WIDTH-1:0]            inflight_label,
    output logic                              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BEATS - 1);

    state_t                             state_q, state_d;
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]               cnt_nxt;
    logic [LABEL_WIDTH-1:0]             label_q, label_d;
    logic [BEATS-1:0][DATA_WIDTH-1:0]   data_q, data_d;
    logic                               awvalid_q, awvalid_d;
    logic                               wvalid_q, wvalid_d;
    logic                               wlast_q, wlast_d;
    logic                               bready_q, bready_d;
    logic                               inflight_q, inflight_d;
    logic                               bus_err_q, bus_err_d;

    // Pop is only offered while idle and out of reset.
    assign pop = rst && (state_q == IDLE) && !empty;

    assign cnt_nxt = cnt_q + CNT_WIDTH'(1);

    assign awaddr         = {label_q, {LINE_BYTE_OFFSET{1'b0}}};
    assign awlen          = 8'(BEATS - 1);
    assign awsize         = 3'($clog2(DATA_WIDTH / 8));
    assign awburst        = 2'b01;
    assign awvalid        = awvalid_q;
    assign wdata          = data_q[cnt_q];
    assign wstrb          = '1;
    assign wlast          = wlast_q;
    assign wvalid         = wvalid_q;
    assign bready         = bready_q;
    assign inflight_valid = inflight_q;
    assign inflight_label = label_q;
    assign bus_err        = bus_err_q;

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        label_d    = label_q;
        data_d     = data_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        bready_d   = bready_q;
        inflight_d = inflight_q;
        bus_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    label_d    = rline[LINE_WIDTH +: LABEL_WIDTH];
                    data_d     = rline[LINE_WIDTH-1:0];
                    inflight_d = 1'b1;
                    awvalid_d  = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    cnt_d     = '0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (BEATS == 1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (wready) begin
                    if (cnt_q == LAST) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = cnt_nxt;
                        wlast_d = (cnt_nxt == LAST);
                    end
                end
            end
            RESP: begin
                if (bvalid) begin
                    bready_d   = 1'b0;
                    inflight_d = 1'b0;
                    bus_err_d  = (bresp != 2'b00);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, line buffer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            label_q    <= '0;
            data_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            inflight_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            label_q    <= label_d;
            data_q     <= data_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            bready_q   <= bready_d;
            inflight_q <= inflight_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_line_writeback.sv
// tb_line_writeback: randomized scoreboard bench for line_writeback.
// A victim-FIFO model feeds lines; a monitor checks AXI traffic.

module tb_line_writeback;

    localparam int LW    = 256;
    localparam int DW    = 32;
    localparam int OFF   = $clog2(LW / 8);
    localparam int LBW   = 32 - OFF;
    localparam int BEATS = LW / DW;

    typedef struct packed {
        logic [LBW-1:0] label;
        logic [LW-1:0]  data;
    } line_t;

    logic              clk;
    logic              rst;
    logic [LBW+LW-1:0] rline;
    logic              empty;
    logic              pop;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic              inflight_valid;
    logic [LBW-1:0]    inflight_label;
    logic              bus_err;

    line_writeback #(.LINE_WIDTH(LW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .rline(rline), .empty(empty), .pop(pop),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .inflight_valid(inflight_valid), .inflight_label(inflight_label),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    line_t fifo[$];
    line_t expq[$];
    line_t cur;
    logic  have_cur = 1'b0;
    logic  aw_done = 1'b0;
    int    beats = 0;
    logic  err_exp = 1'b0;
    logic  pop_s = 1'b0;
    int    aw_p = 100, w_p = 100, b_p = 100;
    int    aw_hold = 0;
    logic  w_toggle = 1'b0;
    logic  force_err = 1'b0;
    int    pop_cnt, aw_cnt, infl_cnt, err_cnt;
    int    pop_cyc_q[$];
    int    b_cyc_q[$];

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] exp_addr(input line_t l);
        return 32'(l.label) * (LW / 8);
    endfunction

    function automatic logic [DW-1:0] exp_word(input line_t l, input int i);
        return DW'(l.data >> (i * DW));
    endfunction

    function automatic void refresh();
        empty = (fifo.size() == 0);
        rline = empty ? '0 : {fifo[0].label, fifo[0].data};
    endfunction

    function automatic void push_line(input line_t l);
        fifo.push_back(l);
        expq.push_back(l);
        refresh();
    endfunction

    function automatic line_t rand_line();
        line_t l;
        l.label = LBW'($urandom);
        for (int i = 0; i < BEATS; i++)
            l.data[i*DW +: DW] = $urandom;
        return l;
    endfunction

    function automatic void clear_stats();
        pop_cnt = 0;
        aw_cnt = 0;
        infl_cnt = 0;
        err_cnt = 0;
        pop_cyc_q.delete();
        b_cyc_q.delete();
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Victim FIFO and AXI slave driver, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (pop_s && fifo.size() > 0) void'(fifo.pop_front());
        refresh();
        if (aw_hold > 0 && awvalid) begin
            awready = 1'b0;
            aw_hold--;
        end else begin
            awready = ($urandom_range(0, 99) < aw_p);
        end
        if (w_toggle) wready = !wready;
        else wready = ($urandom_range(0, 99) < w_p);
        bvalid = ($urandom_range(0, 99) < b_p);
        if (force_err) bresp = 2'b10;
        else if ($urandom_range(0, 3) == 0) bresp = 2'($urandom_range(1, 3));
        else bresp = 2'b00;
    end

    // Monitor: reference model of one-line-at-a-time AXI write bursts.
    always @(negedge clk) begin
        logic e_pop, e_aw, e_w, e_b;
        pop_s = pop;
        if (pop) begin
            pop_cnt++;
            pop_cyc_q.push_back(cyc);
        end
        if (awvalid) aw_cnt++;
        if (inflight_valid) infl_cnt++;
        if (bus_err) err_cnt++;
        if (!rst) begin
            chk("rst_pop", pop, 0);
            chk("rst_awvalid", awvalid, 0);
            chk("rst_wvalid", wvalid, 0);
            chk("rst_wlast", wlast, 0);
            chk("rst_bready", bready, 0);
            chk("rst_inflight", inflight_valid, 0);
            chk("rst_bus_err", bus_err, 0);
            have_cur = 1'b0;
            aw_done = 1'b0;
            beats = 0;
            err_exp = 1'b0;
        end else begin
            e_pop = !have_cur && !empty;
            e_aw  = have_cur && !aw_done;
            e_w   = have_cur && aw_done && beats < BEATS;
            e_b   = have_cur && beats == BEATS;
            chk("pop", pop, e_pop);
            chk("awvalid", awvalid, e_aw);
            chk("wvalid", wvalid, e_w);
            chk("bready", bready, e_b);
            chk("inflight_valid", inflight_valid, have_cur);
            chk("bus_err", bus_err, err_exp);
            if (have_cur) chk("inflight_label", inflight_label, cur.label);
            if (e_aw) begin
                chk("awaddr", awaddr, exp_addr(cur));
                chk("awlen", awlen, BEATS - 1);
                chk("awsize", awsize, $clog2(DW / 8));
                chk("awburst", awburst, 2'b01);
            end
            if (e_w) begin
                chk("wdata", wdata, exp_word(cur, beats));
                chk("wlast", wlast, beats == BEATS - 1);
                chk("wstrb", wstrb, {(DW/8){1'b1}});
            end
            err_exp = 1'b0;
            if (e_b && bvalid) begin
                err_exp = (bresp != 2'b00);
                have_cur = 1'b0;
                b_cyc_q.push_back(cyc);
            end
            if (e_w && wready) beats++;
            if (e_aw && awready) aw_done = 1'b1;
            if (e_pop) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: pop with no expected line");
                end else begin
                    cur = expq.pop_front();
                    have_cur = 1'b1;
                    aw_done = 1'b0;
                    beats = 0;
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((expq.size() != 0 || have_cur) && n < budget);
        #2;
        checks++;
        if (expq.size() != 0 || have_cur) begin
            errors++;
            $display("FAIL timeout %s: %0d lines pending after %0d cycles",
                     tag, expq.size() + int'(have_cur), n);
        end
    endtask

    initial begin
        line_t l;
        int    n;
        rst = 1'b0;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        bresp = 2'b00;
        refresh();
        clear_stats();

        // Reset with a line already queued: pop must stay low.
        repeat (2) @(posedge clk);
        #2;
        l.label = 27'h0012345;
        for (int i = 0; i < BEATS; i++)
            l.data[i*DW +: DW] = 32'h11111111 * (i + 1);
        push_line(l);
        repeat (3) @(posedge clk);
        clear_stats();
        #1 rst = 1'b1;

        // Single line, all readies high.
        wait_idle(100, "single");
        chk("single_pops", pop_cnt, 1);
        chk("single_inflight_cycles", infl_cnt, BEATS + 2);
        if (pop_cyc_q.size() == 1 && b_cyc_q.size() == 1)
            chk("single_latency", b_cyc_q[0] - pop_cyc_q[0], BEATS + 2);
        else
            chk("single_events", b_cyc_q.size(), 1);

        // Empty FIFO for 20 cycles.
        clear_stats();
        repeat (20) @(posedge clk);
        #2;
        chk("empty_pops", pop_cnt, 0);
        chk("empty_awvalid", aw_cnt, 0);
        chk("empty_inflight", infl_cnt, 0);

        // Backpressure: AW held off 3 cycles, W ready toggling.
        clear_stats();
        aw_hold = 3;
        w_toggle = 1'b1;
        push_line(rand_line());
        wait_idle(200, "backpressure");
        w_toggle = 1'b0;
        chk("bp_pops", pop_cnt, 1);
        chk("bp_aw_cycles", aw_cnt, 4);

        // Back-to-back lines with immediate response.
        clear_stats();
        push_line(rand_line());
        push_line(rand_line());
        wait_idle(200, "b2b");
        chk("b2b_pops", pop_cyc_q.size(), 2);
        if (pop_cyc_q.size() == 2 && b_cyc_q.size() >= 1)
            chk("b2b_gap", pop_cyc_q[1] - b_cyc_q[0], 1);

        // Error response.
        clear_stats();
        force_err = 1'b1;
        push_line(rand_line());
        wait_idle(200, "error");
        force_err = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("err_pulse_cycles", err_cnt, 1);

        // Reset in the middle of the data phase.
        push_line(rand_line());
        n = 0;
        while (!(have_cur && beats >= 4) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("rst_reach_beat4", beats >= 4, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_awvalid", awvalid, 0);
        chk("async_wvalid", wvalid, 0);
        chk("async_inflight", inflight_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        push_line(rand_line());
        wait_idle(200, "after_reset");

        // Randomized traffic.
        aw_p = 70;
        w_p = 60;
        b_p = 50;
        for (int k = 0; k < 30; k++) begin
            push_line(rand_line());
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #2;
        end
        wait_idle(5000, "random");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
